kbd_scan_ctrl: RTL and testbench
================================

Name: kbd_scan_ctrl

Overview:
- Sequencing controller between the PS/2 byte receiver and the scan-code/ASCII display path.
- Consumes raw scan bytes and decodes the E0/F0 prefixes.
- Tracks shift and caps-lock state and holds the currently pressed key.
- Drives the key-valid, capital, shift and scan-code inputs of the display datapath, plus a press counter for the count display.

Parameters:
- PREFIX_TIMEOUT, 50000: cycles without a byte after which a pending prefix is discarded.
- CNT_W, 8: width of the key-press counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  one-cycle strobe; in_data holds a complete scan byte.
- in_data  input  8  scan byte from PS/2 receiver.
- key_valid  output  1  a non-modifier key is held; display enable.
- key_code  output  8  make code of the held key; holds last value after release.
- key_ext  output  1  held key was E0-prefixed.
- capital  output  1  caps-lock toggle state.
- shift  output  1  left or right shift held.
- press_pulse  output  1  one-cycle pulse on each new (non-repeat) key press.
- press_cnt  output  CNT_W  count of new presses.
- err_pulse  output  1  one-cycle pulse on 0x00/0xFF byte or prefix timeout.

Behaviour:
- Reset: all outputs and internal flags are 0; FSM enters WAIT; timeout counter is 0. Reset overrides in_valid in the same cycle.
- Bytes are processed only when in_valid=1. All outputs update on the clock edge that samples in_valid, so they are visible the next cycle. No backpressure: every strobe is consumed.
- FSM states: WAIT, E0, F0, E0F0.
  - WAIT: 0xE0 goes to E0. 0xF0 goes to F0. Any other byte is a make, then stay in WAIT.
  - E0: 0xF0 goes to E0F0. 0xE0 stays in E0. Any other byte is an extended make, then go to WAIT.
  - F0: 0xE0 goes to E0 (protocol restart, no error). 0xF0 stays in F0. Any other byte is a break, then go to WAIT.
  - E0F0: any byte other than 0xE0/0xF0 is an extended break, then go to WAIT. 0xE0 goes to E0. 0xF0 stays in E0F0.
- Error bytes 0x00 and 0xFF, in any state: go to WAIT, pulse err_pulse; no other state change.
- Timeout: in E0, F0 or E0F0, the counter increments each cycle with no in_valid. When it reaches PREFIX_TIMEOUT-1: go to WAIT, pulse err_pulse, clear the counter. The counter clears on any in_valid and in WAIT.
- Non-extended make:
  - 0x12 sets lshift. 0x59 sets rshift.
  - 0x58: if caps_held=0, toggle capital and set caps_held. If caps_held=1 (typematic repeat), no change.
- Extended make of 0x12 or 0x59 is ignored entirely (fake shift).
- Other makes (extended or not):
  - New press when key_valid=0, or the code differs from key_code, or the ext flag differs from key_ext.
  - On a new press: key_code<=code, key_ext<=ext, key_valid<=1, press_pulse=1, press_cnt<=press_cnt+1 (wraps all-ones to 0).
  - Otherwise the make is a typematic repeat: no change, no pulse.
- Break:
  - Non-extended 0x12 clears lshift. 0x59 clears rshift. 0x58 clears caps_held; capital is unchanged.
  - For any other code, if key_valid=1 and the code and ext flag match key_code/key_ext, then key_valid<=0. Otherwise ignore it (break of a key no longer tracked).
- shift = lshift | rshift (combinational from registers, so also one cycle after the byte).
- A new make while another key is held replaces the held key (rollover); releasing the earlier key has no effect afterward.

Test Plan:
- After rst, send 0x1C -> next cycle key_valid=1, key_code=0x1C, press_pulse=1 for 1 cycle, press_cnt=1, capital=0, shift=0.
- Send 0x1C, 0x1C, 0x1C (repeat), then 0xF0, 0x1C -> press_cnt stays 1 and only one press_pulse; after 0x1C break, key_valid=0 and key_code still 0x1C.
- Send 0x12, 0x1C, 0xF0, 0x12 -> shift=1 with key_valid=1, code 0x1C; after the shift break shift=0 and key_valid stays 1.
- Send 0x58, 0x58, 0xF0, 0x58, 0x58 -> capital=1 after the first byte, stays 1 through the repeat and break, returns to 0 after the final make.
- Send 0xE0, 0x75 then 0xE0, 0xF0, 0x75 -> key_valid=1, key_ext=1, key_code=0x75, then key_valid=0. Separately send 0xE0, 0x12 -> shift stays 0 and press_cnt unchanged.
- Timeout case, PREFIX_TIMEOUT=8: send 0xF0 then idle 8 cycles -> err_pulse for 1 cycle, FSM in WAIT; then 0x1C is treated as a make (key_valid=1). Separately, 0xFF in any state -> err_pulse, outputs unchanged. Also: preload press_cnt=255 via presses -> the next new press wraps it to 0.

Source files
------------

// File: rtl/kbd_scan_ctrl_if.sv
// kbd_scan_ctrl_if: scan-byte input strobe and display-path outputs of kbd_scan_ctrl.
`default_nettype none

interface kbd_scan_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             capital;
  logic             shift;
  logic             press_pulse;
  logic [CNT_W-1:0] press_cnt;
  logic             err_pulse;

  // Controller side
  modport slave (
    input  in_valid, in_data,
    output key_valid, key_code, key_ext, capital, shift,
           press_pulse, press_cnt, err_pulse
  );

  // Byte source / display side
  modport master (
    output in_valid, in_data,
    input  key_valid, key_code, key_ext, capital, shift,
           press_pulse, press_cnt, err_pulse
  );
endinterface

`default_nettype wire

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: decodes PS/2 E0/F0 prefixes, tracks shift/caps-lock and the held key.
// Revision: 1.0
`default_nettype none

module kbd_scan_ctrl #(
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int CNT_W          = 8
) (
  input  wire              clk,
  input  wire              rst,
  kbd_scan_ctrl_if.slave   bus
);
  localparam int C_TMO_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(PREFIX_TIMEOUT - 1);
  localparam logic [7:0] C_PFX_EXT = 8'hE0;
  localparam logic [7:0] C_PFX_BRK = 8'hF0;
  localparam logic [7:0] C_LSHIFT  = 8'h12;
  localparam logic [7:0] C_RSHIFT  = 8'h59;
  localparam logic [7:0] C_CAPS    = 8'h58;

  typedef enum logic [1:0] {S_WAIT, S_E0, S_F0, S_E0F0} state_t;

  state_t             r_state;
  logic [C_TMO_W-1:0] r_tmo;
  logic               r_lshift, r_rshift, r_caps_held, r_capital;
  logic               r_key_valid, r_key_ext, r_press_pulse, r_err_pulse;
  logic [7:0]         r_key_code;
  logic [CNT_W-1:0]   r_press_cnt;

  logic w_err_byte, w_ext, w_brk, w_modifier, w_same_key;

  assign w_err_byte = (bus.in_data == 8'h00) || (bus.in_data == 8'hFF);
  assign w_ext      = (r_state == S_E0) || (r_state == S_E0F0);
  assign w_brk      = (r_state == S_F0) || (r_state == S_E0F0);
  // Shift codes are modifiers in both forms: extended ones are fake shifts and ignored.
  assign w_modifier = (bus.in_data == C_LSHIFT) || (bus.in_data == C_RSHIFT) ||
                      (!w_ext && bus.in_data == C_CAPS);
  assign w_same_key = r_key_valid && (bus.in_data == r_key_code) && (w_ext == r_key_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_WAIT;
      r_tmo         <= '0;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_caps_held   <= 1'b0;
      r_capital     <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_ext     <= 1'b0;
      r_key_code    <= 8'h00;
      r_press_pulse <= 1'b0;
      r_press_cnt   <= '0;
      r_err_pulse   <= 1'b0;
    end else begin
      r_press_pulse <= 1'b0;
      r_err_pulse   <= 1'b0;
      if (bus.in_valid) begin
        r_tmo <= '0;
        if (w_err_byte) begin
          r_state     <= S_WAIT;
          r_err_pulse <= 1'b1;
        end else if (bus.in_data == C_PFX_EXT) begin
          r_state <= S_E0;
        end else if (bus.in_data == C_PFX_BRK) begin
          r_state <= w_ext ? S_E0F0 : S_F0;
        end else begin
          r_state <= S_WAIT;
          if (!w_brk) begin
            if (w_modifier) begin
              if (!w_ext) begin
                if (bus.in_data == C_LSHIFT) r_lshift <= 1'b1;
                if (bus.in_data == C_RSHIFT) r_rshift <= 1'b1;
                if (bus.in_data == C_CAPS && !r_caps_held) begin
                  r_capital   <= ~r_capital;
                  r_caps_held <= 1'b1;
                end
              end
            end else if (!w_same_key) begin
              r_key_code    <= bus.in_data;
              r_key_ext     <= w_ext;
              r_key_valid   <= 1'b1;
              r_press_pulse <= 1'b1;
              r_press_cnt   <= r_press_cnt + 1'b1;
            end
          end else begin
            if (!w_ext && bus.in_data == C_LSHIFT)     r_lshift    <= 1'b0;
            else if (!w_ext && bus.in_data == C_RSHIFT) r_rshift    <= 1'b0;
            else if (!w_ext && bus.in_data == C_CAPS)   r_caps_held <= 1'b0;
            else if (w_same_key)                        r_key_valid <= 1'b0;
          end
        end
      end else if (r_state != S_WAIT) begin
        // A prefix left dangling too long is dropped so the next byte starts fresh.
        if (r_tmo == C_TMO_LAST) begin
          r_state     <= S_WAIT;
          r_err_pulse <= 1'b1;
          r_tmo       <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign bus.key_valid   = r_key_valid;
  assign bus.key_code    = r_key_code;
  assign bus.key_ext     = r_key_ext;
  assign bus.capital     = r_capital;
  assign bus.shift       = r_lshift | r_rshift;
  assign bus.press_pulse = r_press_pulse;
  assign bus.press_cnt   = r_press_cnt;
  assign bus.err_pulse   = r_err_pulse;

endmodule

`default_nettype wire

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: directed scan-byte sequences against hand-computed outputs.
`default_nettype none

module tb_kbd_scan_ctrl;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  kbd_scan_ctrl_if #(.CNT_W(CNT_W)) bus ();

  kbd_scan_ctrl #(.PREFIX_TIMEOUT(8), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One strobe; returns on the negedge after the sampling edge so outputs are settled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_state(input string tag, input logic kv, input logic [7:0] code,
                           input logic ext, input logic [7:0] cnt);
    check({tag, ".kv"},   32'(bus.key_valid), 32'(kv));
    check({tag, ".code"}, 32'(bus.key_code),  32'(code));
    check({tag, ".ext"},  32'(bus.key_ext),   32'(ext));
    check({tag, ".cnt"},  32'(bus.press_cnt), 32'(cnt));
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h1C;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    idle(1);

    key_state("rst", 1'b0, 8'h00, 1'b0, 8'd0);
    check("rst.cap",   32'(bus.capital),     0);
    check("rst.shift", 32'(bus.shift),       0);
    check("rst.pp",    32'(bus.press_pulse), 0);
    check("rst.err",   32'(bus.err_pulse),   0);

    send(8'h1C);
    key_state("make1", 1'b1, 8'h1C, 1'b0, 8'd1);
    check("make1.pp",  32'(bus.press_pulse), 1);
    check("make1.cap", 32'(bus.capital),     0);
    check("make1.sh",  32'(bus.shift),       0);
    idle(1);
    check("make1.pp_end", 32'(bus.press_pulse), 0);

    for (int i = 0; i < 3; i++) begin
      send(8'h1C);
      check("rep.pp", 32'(bus.press_pulse), 0);
    end
    send(8'hF0);
    check("brkpfx.kv", 32'(bus.key_valid), 1);
    send(8'h1C);
    key_state("brk1", 1'b0, 8'h1C, 1'b0, 8'd1);

    send(8'h12);
    check("lsh.sh", 32'(bus.shift), 1);
    send(8'h1C);
    key_state("shmake", 1'b1, 8'h1C, 1'b0, 8'd2);
    check("shmake.sh", 32'(bus.shift), 1);
    send(8'hF0); send(8'h12);
    check("lshbrk.sh", 32'(bus.shift), 0);
    check("lshbrk.kv", 32'(bus.key_valid), 1);

    send(8'h58);
    check("caps1", 32'(bus.capital), 1);
    send(8'h58);
    check("caps_rep", 32'(bus.capital), 1);
    send(8'hF0); send(8'h58);
    check("caps_brk", 32'(bus.capital), 1);
    send(8'h58);
    check("caps2", 32'(bus.capital), 0);
    check("caps.cnt", 32'(bus.press_cnt), 2);

    send(8'hE0); send(8'h75);
    key_state("extmk", 1'b1, 8'h75, 1'b1, 8'd3);
    send(8'hE0); send(8'hF0); send(8'h75);
    key_state("extbrk", 1'b0, 8'h75, 1'b1, 8'd3);
    send(8'hE0); send(8'h12);
    check("fake.sh", 32'(bus.shift), 0);
    check("fake.pp", 32'(bus.press_pulse), 0);
    check("fake.cnt", 32'(bus.press_cnt), 3);

    send(8'hFF);
    check("errff.err", 32'(bus.err_pulse), 1);
    key_state("errff", 1'b0, 8'h75, 1'b1, 8'd3);
    idle(1);
    check("errff.end", 32'(bus.err_pulse), 0);
    send(8'hF0); send(8'hFF);
    check("errf0.err", 32'(bus.err_pulse), 1);
    send(8'h1C);
    key_state("afterr", 1'b1, 8'h1C, 1'b0, 8'd4);
    send(8'hE0); send(8'h00);
    check("err00.err", 32'(bus.err_pulse), 1);
    send(8'h75);
    key_state("err00mk", 1'b1, 8'h75, 1'b0, 8'd5);

    send(8'hF0);
    idle(7);
    check("tmo.early", 32'(bus.err_pulse), 0);
    idle(1);
    check("tmo.err", 32'(bus.err_pulse), 1);
    idle(1);
    check("tmo.end", 32'(bus.err_pulse), 0);
    send(8'h1C);
    key_state("tmomk", 1'b1, 8'h1C, 1'b0, 8'd6);

    send(8'h2A);
    key_state("roll", 1'b1, 8'h2A, 1'b0, 8'd7);
    send(8'hF0); send(8'h1C);
    check("roll.oldbrk", 32'(bus.key_valid), 1);

    for (int i = 0; i < 248; i++) send((i % 2) ? 8'h16 : 8'h15);
    check("cnt255", 32'(bus.press_cnt), 255);
    send(8'h1D);
    check("wrap.cnt", 32'(bus.press_cnt), 0);
    check("wrap.pp",  32'(bus.press_pulse), 1);
    send(8'hE0); send(8'h1D);
    key_state("extdiff", 1'b1, 8'h1D, 1'b1, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
